// File: rtl/i2s_rx.sv
// Master-mode I2S receiver. Generates MCLK/SCK/LRCK from the 100 MHz system
// clock with one free-running 11-bit counter, deserialises sdin MSB-first and
// presents one stereo pair per 2048-clk frame on a valid/ready output.
//
// Output handshake: out_valid rises when a completed frame loads left/right.
// The pair is consumed on a clk edge where out_valid && out_ready, after which
// out_valid drops unless a new frame completes on that same edge. out_ready
// with out_valid low does nothing. A frame completing while a pair is still
// pending and not being accepted overwrites it and sets the sticky overrun.
module i2s_rx #(
   parameter int WIDTH       = 24,
   parameter int SKIP_FRAMES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sdin,
   output logic             mclk,
   output logic             sck,
   output logic             lrck,
   output logic [WIDTH-1:0] left,
   output logic [WIDTH-1:0] right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   localparam logic [4:0] LAST_SLOT = 5'(WIDTH);
   localparam logic [3:0] SKIP_INIT = 4'(SKIP_FRAMES);

   logic [10:0]      cnt;
   logic             sdin_q;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_next;
   logic [WIDTH-1:0] hold;
   logic [3:0]       skip;

   logic       strobe;
   logic [4:0] slot;
   logic       ch;
   logic       data_slot;
   logic       last_slot;
   logic       left_done;
   logic       frame_done;

   // Audio clocks are taken straight from counter flops, so they never glitch.
   assign mclk = cnt[1];
   assign sck  = cnt[4];
   assign lrck = cnt[10];

   // First clk with SCK high; sdin_q then holds the bit seen at the SCK rise.
   assign strobe     = (cnt[4:0] == 5'd16);
   assign slot       = cnt[9:5];
   assign ch         = cnt[10];
   assign data_slot  = strobe && (slot != 5'd0) && (slot <= LAST_SLOT);
   assign last_slot  = strobe && (slot == LAST_SLOT);
   assign left_done  = last_slot && !ch;
   assign frame_done = last_slot && ch;

   // Shift register contents including the bit being captured this cycle,
   // so the LSB can be forwarded to hold/output on the capture edge itself.
   assign shift_next = WIDTH'({shift, sdin_q});

   // Free-running frame counter and the sdin input register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         sdin_q <= 1'b0;
      end else begin
         cnt    <= cnt + 11'd1;
         sdin_q <= sdin;
      end
   end

   // Deserialise data slots; latch the finished left word until the right word ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift <= '0;
         hold  <= '0;
      end else begin
         if (data_slot) begin
            shift <= shift_next;
         end
         if (left_done) begin
            hold <= shift_next;
         end
      end
   end

   // Frame completion, startup frame skipping, output handshake and overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skip      <= SKIP_INIT;
         left      <= '0;
         right     <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (frame_done && (skip != 4'd0)) begin
         skip <= skip - 4'd1;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end else if (frame_done) begin
         left      <= hold;
         right     <= shift_next;
         out_valid <= 1'b1;
         if (out_valid && !out_ready) begin
            overrun <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: three instances (24-bit no skip, 24-bit skip 2, 16-bit no
// skip) fed by an I2S ADC model that serialises per-frame sample tables.
module tb_i2s_rx;

   localparam int FRAME = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance a: WIDTH 24, SKIP_FRAMES 0
   logic        rst_a, sdin_a, rdy_a, mclk_a, sck_a, lrck_a, ov_a, orun_a;
   logic [23:0] left_a, right_a;
   // Instance s: WIDTH 24, SKIP_FRAMES 2
   logic        rst_s, sdin_s, rdy_s, mclk_s, sck_s, lrck_s, ov_s, orun_s;
   logic [23:0] left_s, right_s;
   // Instance n: WIDTH 16, SKIP_FRAMES 0
   logic        rst_n, sdin_n, rdy_n, mclk_n, sck_n, lrck_n, ov_n, orun_n;
   logic [15:0] left_n, right_n;

   logic [31:0] la[16], ra[16], ls[16], rs[16], ln[16], rn[16];
   int          base_a;
   int          k_a, k_s, k_n;
   int          g;
   int          checks, failures;
   logic [47:0] exp_q[$];

   i2s_rx #(.WIDTH(24), .SKIP_FRAMES(0)) u_a (
      .clk(clk), .rst(rst_a), .sdin(sdin_a), .mclk(mclk_a), .sck(sck_a),
      .lrck(lrck_a), .left(left_a), .right(right_a), .out_valid(ov_a),
      .out_ready(rdy_a), .overrun(orun_a));

   i2s_rx #(.WIDTH(24), .SKIP_FRAMES(2)) u_s (
      .clk(clk), .rst(rst_s), .sdin(sdin_s), .mclk(mclk_s), .sck(sck_s),
      .lrck(lrck_s), .left(left_s), .right(right_s), .out_valid(ov_s),
      .out_ready(rdy_s), .overrun(orun_s));

   i2s_rx #(.WIDTH(16), .SKIP_FRAMES(0)) u_n (
      .clk(clk), .rst(rst_n), .sdin(sdin_n), .mclk(mclk_n), .sck(sck_n),
      .lrck(lrck_n), .left(left_n), .right(right_n), .out_valid(ov_n),
      .out_ready(rdy_n), .overrun(orun_n));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ADC model: bit driven during clk index c of a frame (slot = c/32,
   // channel = c/1024); slot 1 carries the MSB, unused slots idle high.
   function automatic logic adc_bit(input int c, input int w,
                                    input logic [31:0] l, input logic [31:0] r);
      int          b;
      logic [31:0] s;
      b = (c / 32) % 32;
      s = (c >= 1024) ? r : l;
      if (b >= 1 && b <= w) return s[w - b];
      return 1'b1;
   endfunction

   // Clocks elapsed since each instance left reset.
   always @(posedge clk) begin
      k_a <= rst_a ? 0 : k_a + 1;
      k_s <= rst_s ? 0 : k_s + 1;
      k_n <= rst_n ? 0 : k_n + 1;
   end

   // Drive sdin on the falling edge of clk, which covers every SCK fall.
   initial begin
      sdin_a = 1'b1;
      sdin_s = 1'b1;
      sdin_n = 1'b1;
      forever begin
         @(negedge clk);
         sdin_a = adc_bit(k_a % FRAME, 24, la[(base_a + k_a / FRAME) % 16],
                          ra[(base_a + k_a / FRAME) % 16]);
         sdin_s = adc_bit(k_s % FRAME, 24, ls[(k_s / FRAME) % 16], rs[(k_s / FRAME) % 16]);
         sdin_n = adc_bit(k_n % FRAME, 16, ln[(k_n / FRAME) % 16], rn[(k_n / FRAME) % 16]);
      end
   end

   // Scoreboard for instance s: queue each pair the ADC finished (from frame
   // SKIP_FRAMES on), randomly consume, and compare at each accepting edge.
   task automatic sb_step();
      int f;
      f = g / FRAME;
      if ((g % FRAME) == 1809 && f >= 2)
         exp_q.push_back({ls[f % 16][23:0], rs[f % 16][23:0]});
      rdy_s = ($urandom_range(0, 3) != 0);
      if (ov_s && rdy_s) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_pair", 32'd1, 32'd0);
         end else begin
            check("sb_left", 32'(left_s), 32'(exp_q[0][47:24]));
            check("sb_right", 32'(right_s), 32'(exp_q[0][23:0]));
            void'(exp_q.pop_front());
         end
      end
   endtask

   initial begin
      int wave_err, lrck_first, first_s, early_a, early_n;
      checks = 0; failures = 0; g = 0; base_a = 0;
      wave_err = 0; lrck_first = -1; first_s = -1; early_a = 0; early_n = 0;
      rst_a = 1'b1; rst_s = 1'b1; rst_n = 1'b1;
      rdy_a = 1'b0; rdy_s = 1'b0; rdy_n = 1'b0;
      for (int i = 0; i < 16; i++) begin
         la[i] = $urandom & 32'hFF_FFFF;
         ra[i] = $urandom & 32'hFF_FFFF;
         ls[i] = $urandom & 32'hFF_FFFF;
         rs[i] = $urandom & 32'hFF_FFFF;
         ln[i] = $urandom & 32'hFFFF;
         rn[i] = $urandom & 32'hFFFF;
      end
      la[0] = 32'hABCDEF; ra[0] = 32'h123456;
      ls[2] = 32'hABCDEF; rs[2] = 32'h123456;
      ln[0] = 32'h8001;   rn[0] = 32'h7FFE;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_mclk", 32'(mclk_a), 32'd0);
      check("rst_sck", 32'(sck_a), 32'd0);
      check("rst_lrck", 32'(lrck_a), 32'd0);
      check("rst_left", 32'(left_a), 32'd0);
      check("rst_right", 32'(right_a), 32'd0);
      check("rst_valid", 32'(ov_a), 32'd0);
      check("rst_overrun", 32'(orun_a), 32'd0);
      check("rst_valid_s", 32'(ov_s), 32'd0);
      check("rst_valid_n", 32'(ov_n), 32'd0);
      rst_a = 1'b0; rst_s = 1'b0; rst_n = 1'b0;

      for (int step = 1; step <= 4 * FRAME + 500; step++) begin
         @(posedge clk);
         #1;
         g = step;
         if (mclk_a !== 1'((g >> 1) & 1)) wave_err++;
         if (sck_a  !== 1'((g >> 4) & 1)) wave_err++;
         if (lrck_a !== 1'((g >> 10) & 1)) wave_err++;
         if (lrck_a && lrck_first < 0) lrck_first = g;
         if (ov_s && first_s < 0) first_s = g;
         if (g < 1809 && ov_a) early_a++;
         if (g < 1553 && ov_n) early_n++;

         // Instance a: basic capture, overrun, single-cycle accept
         if (g == 1809) begin
            check("a_valid_rise", 32'(ov_a), 32'd1);
            check("a_left0", 32'(left_a), 32'hABCDEF);
            check("a_right0", 32'(right_a), 32'h123456);
            check("a_no_overrun", 32'(orun_a), 32'd0);
         end
         if (g == 3856) check("a_overrun_pre", 32'(orun_a), 32'd0);
         if (g == 3857) begin
            check("a_overrun_set", 32'(orun_a), 32'd1);
            check("a_left1", 32'(left_a), la[1]);
            check("a_right1", 32'(right_a), ra[1]);
         end
         if (g == 4001) begin
            check("a_valid_cleared", 32'(ov_a), 32'd0);
            check("a_overrun_sticky", 32'(orun_a), 32'd1);
            rdy_a = 1'b0;
         end
         if (g == 4000) rdy_a = 1'b1;
         if (g == 4500) rdy_a = 1'b1;
         if (g == 5904) begin
            check("a_idle_ready_no_valid", 32'(ov_a), 32'd0);
            rdy_a = 1'b0;
         end
         if (g == 5905) begin
            check("a_valid_frame2", 32'(ov_a), 32'd1);
            check("a_left2", 32'(left_a), la[2]);
            check("a_right2", 32'(right_a), ra[2]);
         end
         if (g == 8000) check("a_overrun_still", 32'(orun_a), 32'd1);

         // Instance s: data check at first valid frame
         if (g == 5905) begin
            check("s_left2", 32'(left_s), 32'hABCDEF);
            check("s_right2", 32'(right_s), 32'h123456);
         end

         // Instance n: narrow width, accept coinciding with completion
         if (g == 1553) begin
            check("n_valid_rise", 32'(ov_n), 32'd1);
            check("n_left0", 32'(left_n), 32'h8001);
            check("n_right0", 32'(right_n), 32'h7FFE);
         end
         if (g == 3601) begin
            check("n_coincide_valid", 32'(ov_n), 32'd1);
            check("n_coincide_left", 32'(left_n), ln[1]);
            check("n_coincide_right", 32'(right_n), rn[1]);
            check("n_coincide_no_overrun", 32'(orun_n), 32'd0);
         end
         if (g == 3602) begin
            check("n_accept_clear", 32'(ov_n), 32'd0);
            rdy_n = 1'b0;
         end
         if (g == 3600) rdy_n = 1'b1;

         sb_step();
      end

      check("clk_waveforms_err", wave_err, 0);
      check("lrck_first_rise", lrck_first, 1024);
      check("a_valid_early", early_a, 0);
      check("n_valid_early", early_n, 0);
      check("s_first_valid", first_s, 2 * FRAME + 1809);

      // Reset instance a mid-frame (cnt = 500); a fresh table entry follows.
      rst_a  = 1'b1;
      base_a = 8;
      #1;
      check("mid_rst_overrun", 32'(orun_a), 32'd0);
      check("mid_rst_valid", 32'(ov_a), 32'd0);
      check("mid_rst_left", 32'(left_a), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         g++;
         sb_step();
      end
      rst_a    = 1'b0;
      wave_err = 0;
      early_a  = 0;
      for (int k = 1; k <= 1810; k++) begin
         @(posedge clk);
         #1;
         g++;
         sb_step();
         if (mclk_a !== 1'((k >> 1) & 1)) wave_err++;
         if (lrck_a !== 1'((k >> 10) & 1)) wave_err++;
         if (k < 1809 && ov_a) early_a++;
         if (k == 1809) begin
            check("re_valid", 32'(ov_a), 32'd1);
            check("re_left", 32'(left_a), la[8]);
            check("re_right", 32'(right_a), ra[8]);
            check("re_overrun", 32'(orun_a), 32'd0);
         end
      end
      check("re_clk_waveforms_err", wave_err, 0);
      check("re_valid_early", early_a, 0);
      check("s_overrun", 32'(orun_s), 32'd0);
      check("sb_backlog_ok", 32'(exp_q.size() <= 1), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
